// File: rtl/ddr_word_cache.sv
// ddr_word_cache: direct-mapped, one-word-per-line, write-through read cache in front of the DDR controller.
// Define DDR_CACHE_STATS_EN to add the stat_hits/stat_misses counters.
module ddr_word_cache #(
  parameter int INDEX_BITS = 8,
  parameter int TAG_BITS = 22 - INDEX_BITS
) (
  input  logic        clkrv,
  input  logic        rst,
  input  logic [23:0] s_addr,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] s_rdata,
  output logic [23:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  input  logic        flush
`ifdef DDR_CACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic [2:0] {IDLE, LOOKUP, DDR_REQ, RESP, GAP} state_t;
  state_t state, state_n;
  logic [21:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0] wstrb_q;
  logic [31:0] data_mem [LINES];
  logic [TAG_BITS-1:0] tag_mem [LINES];
  logic [LINES-1:0] valid;
  logic [31:0] rd_data, merged;
  logic [TAG_BITS-1:0] rd_tag, tag_q;
  logic [INDEX_BITS-1:0] idx_q, s_idx;
  logic hit, hit_q, is_wr, done, fill, merge, unused_addr;
  assign s_idx = s_addr[INDEX_BITS+1:2];
  assign idx_q = addr_q[INDEX_BITS-1:0];
  assign tag_q = addr_q[21:INDEX_BITS];
  assign is_wr = |wstrb_q;
  assign hit = valid[idx_q] && rd_tag == tag_q;
  assign done = state == DDR_REQ && m_ready;
  assign fill = done && !is_wr;
  assign merge = done && is_wr && hit_q;
  assign unused_addr = ^s_addr[1:0];
  always_comb begin
    merged = rd_data;
    for (int i = 0; i < 4; i++) merged[8*i+:8] = wstrb_q[i] ? wdata_q[8*i+:8] : rd_data[8*i+:8];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = s_valid ? LOOKUP : IDLE;
      LOOKUP:  state_n = (!is_wr && hit) ? RESP : DDR_REQ;
      DDR_REQ: state_n = m_ready ? RESP : DDR_REQ;
      RESP:    state_n = GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clkrv or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Flush has priority over a fill landing on the same edge.
  always_ff @(posedge clkrv or posedge rst)
    if (rst) valid <= '0;
    else if (flush) valid <= '0;
    else if (fill) valid[idx_q] <= 1'b1;
  always_ff @(posedge clkrv) begin
    if (state == IDLE && s_valid) begin
      rd_data <= data_mem[s_idx];
      rd_tag <= tag_mem[s_idx];
    end
    if (fill) begin
      data_mem[idx_q] <= m_rdata;
      tag_mem[idx_q] <= tag_q;
    end else if (merge) data_mem[idx_q] <= merged;
  end
  always_ff @(posedge clkrv or posedge rst)
    if (rst) begin
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      hit_q <= 1'b0;
      s_ready <= 1'b0;
      s_rdata <= '0;
      m_valid <= 1'b0;
      m_addr <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
`ifdef DDR_CACHE_STATS_EN
      stat_hits <= '0;
      stat_misses <= '0;
`endif
    end else begin
      if (state == IDLE && s_valid) begin
        addr_q <= s_addr[23:2];
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (state == LOOKUP) begin
        hit_q <= hit;
        if (!is_wr && hit) begin
          s_ready <= 1'b1;
          s_rdata <= rd_data;
        end else begin
          m_addr <= {addr_q, 2'b00};
          m_wdata <= wdata_q;
          m_wstrb <= wstrb_q;
          m_valid <= 1'b1;
        end
`ifdef DDR_CACHE_STATS_EN
        if (!is_wr && hit) stat_hits <= stat_hits + 32'd1;
        if (!is_wr && !hit) stat_misses <= stat_misses + 32'd1;
`endif
      end
      if (done) begin
        m_valid <= 1'b0;
        s_ready <= 1'b1;
        s_rdata <= is_wr ? 32'd0 : m_rdata;
      end
      if (state == RESP) s_ready <= 1'b0;
    end
endmodule

// File: tb/tb_ddr_word_cache.sv
// tb_ddr_word_cache: randomized and directed checks of ddr_word_cache against a DDR memory model
// and an abstract map of which word address each cache index currently holds.
module tb_ddr_word_cache;
  logic clkrv = 0, rst = 1;
  logic [23:0] s_addr = '0, m_addr;
  logic [31:0] s_wdata = '0, s_rdata, m_wdata, m_rdata = '0;
  logic [3:0] s_wstrb = '0, m_wstrb;
  logic s_valid = 0, s_ready, m_valid, m_ready = 0, flush = 0;
`ifdef DDR_CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif
  ddr_word_cache dut (
    .clkrv(clkrv), .rst(rst), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_valid(m_valid), .m_ready(m_ready), .m_rdata(m_rdata), .flush(flush)
`ifdef DDR_CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses)
`endif
  );
  always #5 clkrv = ~clkrv;
  int n_checks = 0, n_fail = 0;
  logic [31:0] ddr_mem [int];
  int cached [int];
  int ddr_txn = 0, ddr_lat = -1, exp_hits = 0, exp_misses = 0;
  bit ddr_hold = 0, flush_on_ready = 0;
  logic [23:0] last_addr;
  logic [31:0] last_wdata;
  logic [3:0] last_wstrb;

  initial begin : ddr_model
    int wa, lat;
    logic [31:0] w;
    forever begin
      @(negedge clkrv);
      if (m_valid && !rst) begin
        ddr_txn++;
        last_addr = m_addr;
        last_wdata = m_wdata;
        last_wstrb = m_wstrb;
        lat = ddr_lat >= 0 ? ddr_lat : int'($urandom_range(0, 4));
        repeat (lat) @(negedge clkrv);
        while (ddr_hold) @(negedge clkrv);
        if (m_valid) begin
          wa = int'(m_addr[23:2]);
          if (!ddr_mem.exists(wa)) ddr_mem[wa] = $urandom;
          w = ddr_mem[wa];
          for (int i = 0; i < 4; i++) if (m_wstrb[i]) w[8*i+:8] = m_wdata[8*i+:8];
          ddr_mem[wa] = w;
          m_rdata = (|m_wstrb) ? $urandom : w;
          m_ready = 1;
          if (flush_on_ready) flush = 1;
          @(negedge clkrv);
          m_ready = 0;
          flush = 0;
        end
      end
    end
  end

  task automatic do_req(input logic [23:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input bit fl, output logic [31:0] rd, output int lat, output int txns);
    int t0 = ddr_txn;
    bit seen = 0;
    @(negedge clkrv);
    s_addr = a; s_wdata = wd; s_wstrb = ws; s_valid = 1; flush_on_ready = fl;
    lat = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(posedge clkrv);
      lat++;
      #1;
      seen = s_ready;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL req_timeout addr=%h: s_ready=0 after %0d cycles, required 1", a, lat);
    end
    rd = s_rdata;
    s_valid = 0;
    flush_on_ready = 0;
    txns = ddr_txn - t0;
    repeat (2) @(posedge clkrv);
  endtask

  // Abstract cache: index -> word address held; reads allocate, writes never do.
  task automatic model_access(input logic [23:0] a, input logic [3:0] ws, input bit fl, output bit h);
    int wa = int'(a[23:2]);
    int idx = wa % 256;
    h = cached.exists(idx) && cached[idx] == wa;
    if (ws == 0) begin
      if (h) exp_hits++;
      else begin
        exp_misses++;
        cached[idx] = wa;
      end
    end
    if (fl && !(ws == 0 && h)) cached.delete();
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: s_ready=%b s_rdata=%h m_valid=%b m_addr=%h m_wdata=%h m_wstrb=%b, required all 0",
               s_ready, s_rdata, m_valid, m_addr, m_wdata, m_wstrb);
    end
`ifdef DDR_CACHE_STATS_EN
    n_checks++;
    if (stat_hits !== 0 || stat_misses !== 0) begin
      n_fail++;
      $display("FAIL reset_stats: hits=%0d misses=%0d, required 0 0", stat_hits, stat_misses);
    end
`endif
    repeat (3) @(negedge clkrv);
    rst = 0;
  endtask

  task automatic test_miss_then_hit();
    logic [31:0] rd; int lat, tx; bit h;
    ddr_mem[int'(24'h800100 >> 2)] = 32'hDEADBEEF;
    ddr_lat = 5;
    do_req(24'h800100, 0, 4'b0000, 0, rd, lat, tx); model_access(24'h800100, 0, 0, h);
    ddr_lat = -1;
    n_checks++;
    if (rd !== 32'hDEADBEEF || tx != 1 || last_wstrb !== 0 || last_addr !== 24'h800100) begin
      n_fail++;
      $display("FAIL miss_fill: rdata=%h txns=%0d m_wstrb=%b m_addr=%h, required DEADBEEF 1 0000 800100", rd, tx, last_wstrb, last_addr);
    end
    do_req(24'h800100, 0, 4'b0000, 0, rd, lat, tx); model_access(24'h800100, 0, 0, h);
    n_checks++;
    if (rd !== 32'hDEADBEEF || tx != 0 || lat != 2) begin
      n_fail++;
      $display("FAIL read_hit: rdata=%h txns=%0d latency=%0d, required DEADBEEF 0 2", rd, tx, lat);
    end
  endtask

  task automatic test_write_merge();
    logic [31:0] rd; int lat, tx; bit h;
    do_req(24'h800100, 32'h0000AA00, 4'b0010, 0, rd, lat, tx); model_access(24'h800100, 4'b0010, 0, h);
    n_checks++;
    if (tx != 1 || last_wstrb !== 4'b0010 || last_wdata !== 32'h0000AA00 || last_addr !== 24'h800100) begin
      n_fail++;
      $display("FAIL write_through: txns=%0d m_wstrb=%b m_wdata=%h m_addr=%h, required 1 0010 0000AA00 800100", tx, last_wstrb, last_wdata, last_addr);
    end
    do_req(24'h800100, 0, 4'b0000, 0, rd, lat, tx); model_access(24'h800100, 0, 0, h);
    n_checks++;
    if (rd !== 32'hDEADAAEF || tx != 0 || lat != 2) begin
      n_fail++;
      $display("FAIL merged_hit: rdata=%h txns=%0d latency=%0d, required DEADAAEF 0 2", rd, tx, lat);
    end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd; int lat, tx; bit h;
    do_req(24'h000200, 32'h12345678, 4'b1111, 0, rd, lat, tx); model_access(24'h000200, 4'b1111, 0, h);
    n_checks++;
    if (rd !== 0 || tx != 1) begin
      n_fail++;
      $display("FAIL write_miss: rdata=%h txns=%0d, required 00000000 1", rd, tx);
    end
    do_req(24'h000200, 0, 4'b0000, 0, rd, lat, tx); model_access(24'h000200, 0, 0, h);
    n_checks++;
    if (tx != 1 || last_wstrb !== 0 || rd !== 32'h12345678) begin
      n_fail++;
      $display("FAIL no_allocate: txns=%0d m_wstrb=%b rdata=%h, required 1 0000 12345678", tx, last_wstrb, rd);
    end
  endtask

  task automatic test_alias();
    logic [31:0] rd; int lat, tx; bit h;
    do_req(24'h840100, 0, 4'b0000, 0, rd, lat, tx); model_access(24'h840100, 0, 0, h);
    n_checks++;
    if (tx != 1 || rd !== ddr_mem[int'(24'h840100 >> 2)]) begin
      n_fail++;
      $display("FAIL alias_miss: txns=%0d rdata=%h, required 1 %h", tx, rd, ddr_mem[int'(24'h840100 >> 2)]);
    end
    do_req(24'h800100, 0, 4'b0000, 0, rd, lat, tx); model_access(24'h800100, 0, 0, h);
    n_checks++;
    if (tx != 1 || rd !== 32'hDEADAAEF) begin
      n_fail++;
      $display("FAIL alias_evict: txns=%0d rdata=%h, required 1 DEADAAEF", tx, rd);
    end
  endtask

  task automatic test_flush();
    logic [31:0] rd; int lat, tx; bit h;
    do_req(24'h000400, 0, 4'b0000, 1, rd, lat, tx); model_access(24'h000400, 0, 1, h);
    n_checks++;
    if (tx != 1 || rd !== ddr_mem[int'(24'h000400 >> 2)]) begin
      n_fail++;
      $display("FAIL flush_fill_resp: txns=%0d rdata=%h, required 1 %h", tx, rd, ddr_mem[int'(24'h000400 >> 2)]);
    end
    do_req(24'h800100, 0, 4'b0000, 0, rd, lat, tx); model_access(24'h800100, 0, 0, h);
    n_checks++;
    if (tx != 1) begin
      n_fail++;
      $display("FAIL flush_other_line: txns=%0d, required 1", tx);
    end
    do_req(24'h000400, 0, 4'b0000, 0, rd, lat, tx); model_access(24'h000400, 0, 0, h);
    n_checks++;
    if (tx != 1) begin
      n_fail++;
      $display("FAIL flush_wins_fill: txns=%0d, required 1", tx);
    end
    @(negedge clkrv); flush = 1; @(negedge clkrv); flush = 0;
    cached.delete();
    do_req(24'h000400, 0, 4'b0000, 0, rd, lat, tx); model_access(24'h000400, 0, 0, h);
    n_checks++;
    if (tx != 1) begin
      n_fail++;
      $display("FAIL idle_flush: txns=%0d, required 1", tx);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd; logic [23:0] a; logic [3:0] ws; int lat, tx; bit h, fl;
    for (int n = 0; n < 150; n++) begin
      a = 24'((($urandom_range(0, 2) + 32'h100) << 10) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      ws = $urandom_range(0, 1) ? 4'(($urandom_range(0, 15))) : 4'b0000;
      wd = $urandom;
      fl = $urandom_range(0, 9) == 0;
      do_req(a, wd, ws, fl, rd, lat, tx); model_access(a, ws, fl, h);
      n_checks++;
      if (ws == 0 && (tx != (h ? 0 : 1) || rd !== ddr_mem[int'(a[23:2])] || (h && lat != 2))) begin
        n_fail++;
        $display("FAIL rand_read addr=%h: txns=%0d rdata=%h latency=%0d, required %0d %h %s", a, tx, rd, lat, h ? 0 : 1, ddr_mem[int'(a[23:2])], h ? "2" : "any");
      end
      if (ws != 0 && (tx != 1 || last_wstrb !== ws || last_addr !== {a[23:2], 2'b00} || (!h && rd !== 0))) begin
        n_fail++;
        $display("FAIL rand_write addr=%h: txns=%0d m_wstrb=%b m_addr=%h rdata=%h, required 1 %b %h %s", a, tx, last_wstrb, last_addr, rd, ws, {a[23:2], 2'b00}, h ? "any" : "0");
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd; int lat, tx; bit h, seen = 0;
    ddr_hold = 1;
    @(negedge clkrv);
    s_addr = 24'h00F000; s_wstrb = 0; s_valid = 1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clkrv); #1; seen = m_valid;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL mid_fill_mvalid: m_valid=0 after 20 cycles, required 1");
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if (m_valid !== 0 || s_ready !== 0) begin
      n_fail++;
      $display("FAIL async_reset: m_valid=%b s_ready=%b, required 0 0", m_valid, s_ready);
    end
    s_valid = 0;
    cached.delete(); exp_hits = 0; exp_misses = 0;
`ifdef DDR_CACHE_STATS_EN
    n_checks++;
    if (stat_hits !== 0 || stat_misses !== 0) begin
      n_fail++;
      $display("FAIL reset_stats_mid: hits=%0d misses=%0d, required 0 0", stat_hits, stat_misses);
    end
`endif
    @(negedge clkrv); rst = 0; ddr_hold = 0;
    do_req(24'h00F000, 0, 4'b0000, 0, rd, lat, tx); model_access(24'h00F000, 0, 0, h);
    n_checks++;
    if (tx != 1) begin
      n_fail++;
      $display("FAIL post_reset_miss: txns=%0d, required 1", tx);
    end
  endtask

  initial begin
    test_reset();
    test_miss_then_hit();
    test_write_merge();
    test_write_miss();
    test_alias();
    test_flush();
`ifdef DDR_CACHE_STATS_EN
    n_checks++;
    if (stat_hits !== 32'(exp_hits) || stat_misses !== 32'(exp_misses)) begin
      n_fail++;
      $display("FAIL stats_directed: hits=%0d misses=%0d, required %0d %0d", stat_hits, stat_misses, exp_hits, exp_misses);
    end
`endif
    test_random();
    test_reset_mid_fill();
`ifdef DDR_CACHE_STATS_EN
    n_checks++;
    if (stat_hits !== 32'(exp_hits) || stat_misses !== 32'(exp_misses)) begin
      n_fail++;
      $display("FAIL stats_final: hits=%0d misses=%0d, required %0d %0d", stat_hits, stat_misses, exp_hits, exp_misses);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
